// File: rtl/pwr_seq_fsm_pkg.sv
// ============================================================================
// Module   : pwr_seq_fsm_pkg
// Purpose  : Shared definitions for the power-domain sequencer: 3-bit state
//            encoding, the state enum built on it, and an index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwr_seq_fsm_pkg;

    // State encoding, kept as plain localparams so monitors can decode the
    // state register without depending on the enum type.
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PU_SW   = 3'd1;
    localparam logic [2:0] c_ST_PU_STAB = 3'd2;
    localparam logic [2:0] c_ST_PU_RST  = 3'd3;
    localparam logic [2:0] c_ST_PD_ISO  = 3'd4;
    localparam logic [2:0] c_ST_PD_RST  = 3'd5;
    localparam logic [2:0] c_ST_PD_SW   = 3'd6;
    localparam logic [2:0] c_ST_ERR     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_PU_SW   = c_ST_PU_SW,
        ST_PU_STAB = c_ST_PU_STAB,
        ST_PU_RST  = c_ST_PU_RST,
        ST_PD_ISO  = c_ST_PD_ISO,
        ST_PD_RST  = c_ST_PD_RST,
        ST_PD_SW   = c_ST_PD_SW,
        ST_ERR     = c_ST_ERR
    } state_t;

    // Domain index width; a single domain still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwr_seq_arb.sv
// ============================================================================
// Module   : pwr_seq_arb
// Purpose  : Combinational lowest-index picker over the valid power-up and
//            power-down request vectors.
// Ports    : i_up_vld  [NUM_DOM] domains with a valid power-up request
//            i_dn_vld  [NUM_DOM] domains with a valid power-down request
//            o_hit               any valid request present
//            o_dir               direction of the winner (1 = up)
//            o_idx     [IDX_W]   index of the winning domain
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwr_seq_arb #(
    parameter int NUM_DOM = 4,
    parameter int IDX_W   = 2
)(
    input  logic [NUM_DOM-1:0] i_up_vld,
    input  logic [NUM_DOM-1:0] i_dn_vld,
    output logic               o_hit,
    output logic               o_dir,
    output logic [IDX_W-1:0]   o_idx
);

    // Scan from the top down so the lowest requesting index is written last
    // and therefore wins.
    always_comb begin
        o_hit = 1'b0;
        o_dir = 1'b0;
        o_idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (i_up_vld[i] || i_dn_vld[i]) begin
                o_hit = 1'b1;
                o_dir = i_up_vld[i];
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwr_seq_fsm.sv
// ============================================================================
// Module   : pwr_seq_fsm
// Purpose  : Power-domain sequencer. Powers NUM_DOM domains up or down one at
//            a time in safe order (up: switch, settle, reset release,
//            isolation off; down: the reverse). Monitors the switch ack with
//            a timeout and latches a sticky error until cleared.
// Ports    : mclk       clock
//            mreset_n   synchronous reset, active low
//            req_on     [NUM_DOM] level request to power domain up
//            req_off    [NUM_DOM] level request to power domain down
//            pwr_ack    [NUM_DOM] power switch status (1 = powered)
//            err_clr    clears the error state (pulse)
//            pwr_en     [NUM_DOM] power switch enable
//            iso_en     [NUM_DOM] isolation enable (1 = isolated)
//            dom_rst_n  [NUM_DOM] domain reset, active low
//            dom_on     [NUM_DOM] domain fully up
//            busy       sequencer not idle
//            done       1-cycle pulse on sequence completion
//            cur_dom    [IDX_W] domain being / last sequenced
//            err        sticky timeout error
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwr_seq_fsm
    import pwr_seq_fsm_pkg::*;
#(
    parameter int NUM_DOM  = 4,
    parameter int CNT_W    = 8,
    parameter int STAB_CYC = 4,
    parameter int TMO_CYC  = 16,
    parameter int IDX_W    = idx_width(NUM_DOM)
)(
    input  logic               mclk,
    input  logic               mreset_n,
    input  logic [NUM_DOM-1:0] req_on,
    input  logic [NUM_DOM-1:0] req_off,
    input  logic [NUM_DOM-1:0] pwr_ack,
    input  logic               err_clr,
    output logic [NUM_DOM-1:0] pwr_en,
    output logic [NUM_DOM-1:0] iso_en,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic [NUM_DOM-1:0] dom_on,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   cur_dom,
    output logic               err
);

    localparam logic [CNT_W-1:0] c_TMO_LD  = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] c_STAB_LD = CNT_W'(STAB_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Registered state and outputs
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_DOM-1:0] r_pwr_en;
    logic [NUM_DOM-1:0] r_iso_en;
    logic [NUM_DOM-1:0] r_dom_rst_n;
    logic [NUM_DOM-1:0] r_dom_on;
    logic               r_busy;
    logic               r_done;
    logic [IDX_W-1:0]   r_cur_dom;
    logic               r_err;

    // Next-state values
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_DOM-1:0] w_pwr_en_nxt;
    logic [NUM_DOM-1:0] w_iso_en_nxt;
    logic [NUM_DOM-1:0] w_dom_rst_n_nxt;
    logic [NUM_DOM-1:0] w_dom_on_nxt;
    logic               w_done_nxt;
    logic [IDX_W-1:0]   w_cur_dom_nxt;
    logic               w_err_nxt;

    // Request qualification and arbitration
    logic [NUM_DOM-1:0] w_up_vld;
    logic [NUM_DOM-1:0] w_dn_vld;
    logic               w_arb_hit;
    logic               w_arb_dir;
    logic [IDX_W-1:0]   w_arb_idx;

    // A domain asking for both directions at once is ignored; requests that
    // would not change the domain's state are ignored too.
    assign w_up_vld = req_on  & ~req_off & ~r_dom_on;
    assign w_dn_vld = req_off & ~req_on  &  r_dom_on;

    pwr_seq_arb #(
        .NUM_DOM (NUM_DOM),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_up_vld (w_up_vld),
        .i_dn_vld (w_dn_vld),
        .o_hit    (w_arb_hit),
        .o_dir    (w_arb_dir),
        .o_idx    (w_arb_idx)
    );

    always_ff @(posedge mclk) begin
        if (!mreset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pwr_en    <= '0;
            r_iso_en    <= '1;
            r_dom_rst_n <= '0;
            r_dom_on    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_dom   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pwr_en    <= w_pwr_en_nxt;
            r_iso_en    <= w_iso_en_nxt;
            r_dom_rst_n <= w_dom_rst_n_nxt;
            r_dom_on    <= w_dom_on_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_cur_dom   <= w_cur_dom_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pwr_en_nxt    = r_pwr_en;
        w_iso_en_nxt    = r_iso_en;
        w_dom_rst_n_nxt = r_dom_rst_n;
        w_dom_on_nxt    = r_dom_on;
        w_done_nxt      = 1'b0;
        w_cur_dom_nxt   = r_cur_dom;
        w_err_nxt       = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_hit) begin
                    w_cur_dom_nxt = w_arb_idx;
                    if (w_arb_dir) begin
                        w_pwr_en_nxt[w_arb_idx] = 1'b1;
                        w_cnt_nxt               = c_TMO_LD;
                        w_state_nxt             = ST_PU_SW;
                    end else begin
                        // Isolate first so the domain's outputs are clamped
                        // before its reset or supply move.
                        w_iso_en_nxt[w_arb_idx] = 1'b1;
                        w_dom_on_nxt[w_arb_idx] = 1'b0;
                        w_state_nxt             = ST_PD_ISO;
                    end
                end
            end

            ST_PU_SW: begin
                if (pwr_ack[r_cur_dom]) begin
                    w_cnt_nxt   = c_STAB_LD;
                    w_state_nxt = ST_PU_STAB;
                end else if (r_cnt == '0) begin
                    w_err_nxt                  = 1'b1;
                    w_pwr_en_nxt[r_cur_dom]    = 1'b0;
                    w_iso_en_nxt[r_cur_dom]    = 1'b1;
                    w_dom_rst_n_nxt[r_cur_dom] = 1'b0;
                    w_dom_on_nxt[r_cur_dom]    = 1'b0;
                    w_state_nxt                = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            // Loaded with STAB_CYC-1 and left on zero, so exactly STAB_CYC
            // cycles are spent here.
            ST_PU_STAB: begin
                if (r_cnt == '0) begin
                    w_dom_rst_n_nxt[r_cur_dom] = 1'b1;
                    w_state_nxt                = ST_PU_RST;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            ST_PU_RST: begin
                w_iso_en_nxt[r_cur_dom] = 1'b0;
                w_dom_on_nxt[r_cur_dom] = 1'b1;
                w_done_nxt              = 1'b1;
                w_state_nxt             = ST_IDLE;
            end

            ST_PD_ISO: begin
                w_dom_rst_n_nxt[r_cur_dom] = 1'b0;
                w_state_nxt                = ST_PD_RST;
            end

            ST_PD_RST: begin
                w_pwr_en_nxt[r_cur_dom] = 1'b0;
                w_cnt_nxt               = c_TMO_LD;
                w_state_nxt             = ST_PD_SW;
            end

            ST_PD_SW: begin
                if (!pwr_ack[r_cur_dom]) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_err_nxt                  = 1'b1;
                    w_pwr_en_nxt[r_cur_dom]    = 1'b0;
                    w_iso_en_nxt[r_cur_dom]    = 1'b1;
                    w_dom_rst_n_nxt[r_cur_dom] = 1'b0;
                    w_dom_on_nxt[r_cur_dom]    = 1'b0;
                    w_state_nxt                = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            ST_ERR: begin
                if (err_clr) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pwr_en    = r_pwr_en;
    assign iso_en    = r_iso_en;
    assign dom_rst_n = r_dom_rst_n;
    assign dom_on    = r_dom_on;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_dom   = r_cur_dom;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pwr_seq_fsm.sv
// ============================================================================
// Module   : tb_pwr_seq_fsm
// Purpose  : Self-checking bench for pwr_seq_fsm with a behavioural power
//            switch (ack rises 1 cycle after enable, falls 2 cycles after)
//            and a scoreboard of expected sequence completions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwr_seq_fsm;

    localparam int NUM_DOM = 4;
    localparam int IDX_W   = 2;

    logic               mclk = 1'b0;
    logic               mreset_n;
    logic [NUM_DOM-1:0] req_on;
    logic [NUM_DOM-1:0] req_off;
    logic [NUM_DOM-1:0] pwr_ack;
    logic               err_clr;
    logic [NUM_DOM-1:0] pwr_en;
    logic [NUM_DOM-1:0] iso_en;
    logic [NUM_DOM-1:0] dom_rst_n;
    logic [NUM_DOM-1:0] dom_on;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   cur_dom;
    logic               err;

    // Switch model
    logic [NUM_DOM-1:0] r_h1    = '0;
    logic [NUM_DOM-1:0] r_h2    = '0;
    logic [NUM_DOM-1:0] r_stuck = '0;

    typedef struct packed {
        logic [IDX_W-1:0]   dom;
        logic [NUM_DOM-1:0] on;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        r_h1 <= pwr_en;
        r_h2 <= r_h1;
    end
    assign pwr_ack = (r_h1 | r_h2) & ~r_stuck;

    pwr_seq_fsm #(
        .NUM_DOM  (NUM_DOM),
        .CNT_W    (8),
        .STAB_CYC (4),
        .TMO_CYC  (16)
    ) dut (
        .mclk      (mclk),
        .mreset_n  (mreset_n),
        .req_on    (req_on),
        .req_off   (req_off),
        .pwr_ack   (pwr_ack),
        .err_clr   (err_clr),
        .pwr_en    (pwr_en),
        .iso_en    (iso_en),
        .dom_rst_n (dom_rst_n),
        .dom_on    (dom_on),
        .busy      (busy),
        .done      (done),
        .cur_dom   (cur_dom),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        if (done !== 1'b1) chk(tag, 32'd0, 32'd1);
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation.
    always @(negedge mclk) begin
        if (mreset_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_cur_dom", cur_dom, e.dom);
                chk("sb_dom_on", dom_on, e.on);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        mreset_n = 1'b0;
        req_on   = '0;
        req_off  = '0;
        err_clr  = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_pwr_en", pwr_en, 4'h0);
        chk("rst_iso_en", iso_en, 4'hF);
        chk("rst_dom_rst_n", dom_rst_n, 4'h0);
        chk("rst_dom_on", dom_on, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cur_dom", cur_dom, 2'd0);
        chk("rst_err", err, 1'b0);
        mreset_n = 1'b1;
        tick();

        // Domain 0 up, ack one cycle after enable
        req_on = 4'b0001;
        sb_q.push_back('{dom: 2'd0, on: 4'b0001});
        tick();
        chk("up0_pwr_en_e1", pwr_en, 4'b0001);
        chk("up0_busy_e1", busy, 1'b1);
        for (int k = 2; k <= 6; k++) tick();
        chk("up0_rst_e6", dom_rst_n, 4'b0000);
        tick();
        chk("up0_rst_e7", dom_rst_n, 4'b0001);
        chk("up0_iso_e7", iso_en, 4'hF);
        chk("up0_done_e7", done, 1'b0);
        tick();
        chk("up0_iso_e8", iso_en, 4'b1110);
        chk("up0_on_e8", dom_on, 4'b0001);
        chk("up0_done_e8", done, 1'b1);
        req_on = '0;
        tick();
        chk("up0_busy_e9", busy, 1'b0);
        chk("up0_done_e9", done, 1'b0);

        // Two requests together: domain 1 first, then domain 3
        req_on = 4'b1010;
        sb_q.push_back('{dom: 2'd1, on: 4'b0011});
        sb_q.push_back('{dom: 2'd3, on: 4'b1011});
        tick();
        chk("dual_cur_first", cur_dom, 2'd1);
        wait_done("dual_wait1", 40);
        chk("dual_busy_gap", busy, 1'b0);
        tick();
        chk("dual_cur_second", cur_dom, 2'd3);
        chk("dual_busy_second", busy, 1'b1);
        wait_done("dual_wait2", 40);
        req_on = '0;
        tick();

        // Domain 2 switch never acks: timeout into ERR
        r_stuck = 4'b0100;
        req_on  = 4'b0100;
        tick();
        chk("tmo_pwr_en_e1", pwr_en, 4'b1111);
        req_on = '0;
        for (int k = 2; k <= 16; k++) tick();
        chk("tmo_err_e16", err, 1'b0);
        tick();
        chk("tmo_err_e17", err, 1'b1);
        chk("tmo_pwr_en_e17", pwr_en, 4'b1011);
        chk("tmo_iso_e17", iso_en, 4'b0100);
        chk("tmo_dom_on_e17", dom_on, 4'b1011);
        tick();
        tick();
        chk("err_hold", err, 1'b1);
        chk("err_busy", busy, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_err", err, 1'b0);
        chk("err_clr_busy", busy, 1'b0);
        chk("err_clr_dom_on", dom_on, 4'b1011);
        r_stuck = '0;
        tick();

        // Domain 0 down, ack falls two cycles after enable drops
        req_off = 4'b0001;
        sb_q.push_back('{dom: 2'd0, on: 4'b1010});
        tick();
        chk("dn_iso_e1", iso_en, 4'b0101);
        chk("dn_on_e1", dom_on, 4'b1010);
        tick();
        chk("dn_rst_e2", dom_rst_n, 4'b1010);
        tick();
        chk("dn_pwr_e3", pwr_en, 4'b1010);
        tick();
        tick();
        chk("dn_done_e5", done, 1'b0);
        tick();
        chk("dn_done_e6", done, 1'b1);
        req_off = '0;
        tick();

        // Conflicting requests on the same bit are ignored
        req_on  = 4'b0011;
        req_off = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("conflict_busy", busy, 1'b0);
        end
        req_on  = '0;
        req_off = '0;
        tick();

        // Reset in the middle of the settle wait
        req_on = 4'b0001;
        for (int k = 1; k <= 4; k++) tick();
        chk("midrst_busy_pre", busy, 1'b1);
        chk("midrst_rst_pre", dom_rst_n[0], 1'b0);
        mreset_n = 1'b0;
        tick();
        chk("midrst_pwr_en", pwr_en, 4'h0);
        chk("midrst_iso_en", iso_en, 4'hF);
        chk("midrst_dom_rst_n", dom_rst_n, 4'h0);
        chk("midrst_dom_on", dom_on, 4'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cur_dom", cur_dom, 2'd0);
        chk("midrst_err", err, 1'b0);
        mreset_n = 1'b1;
        req_on   = '0;
        tick();
        chk("midrst_idle_after", busy, 1'b0);
        tick();

        chk("sb_leftover", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
